// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: HALT/RUN/STEP clock-enable generator with debounced single-step and selectable tick divider
module cpu_clock_ctrl #(
  parameter logic [31:0] DIV_0     = 32'd50000000,
  parameter logic [31:0] DIV_1     = 32'd5000000,
  parameter logic [31:0] DIV_2     = 32'd500000,
  parameter logic [31:0] DIV_3     = 32'd1,
  parameter logic [31:0] DB_CYCLES = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic        halt_req,
  input  logic [1:0]  div_sel,
  output logic        cpu_ce,
  output logic [1:0]  mode,
  output logic [31:0] cycle_cnt
);
  typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP = 2'b10} state_t;
  state_t state, state_n;
  logic [1:0] run_q, step_q, div_q;
  logic run_s, step_s, db_val, db_prev, step_pulse, div_chg, ce_n, stay_run;
  logic [31:0] db_cnt, tick, period;
  assign run_s = run_q[1];
  assign step_s = step_q[1];
  assign step_pulse = db_val & ~db_prev;
  assign div_chg = div_sel != div_q;
  assign period = div_q == 2'd0 ? DIV_0 : div_q == 2'd1 ? DIV_1 : div_q == 2'd2 ? DIV_2 : DIV_3;
  assign mode = state;
  assign stay_run = state == RUN && state_n == RUN;
  always_comb begin
    state_n = HALT;
    ce_n = 1'b0;
    state_n = state == HALT ? (halt_req ? HALT : run_s ? RUN : step_pulse ? STEP : HALT) :
              state == RUN  ? ((halt_req || !run_s) ? HALT : RUN) : HALT;
    // a rate change swallows the tick so the new period starts cleanly from zero
    ce_n = (state == HALT && state_n == STEP) || (stay_run && !div_chg && tick == period - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q     <= '0;
      step_q    <= '0;
      div_q     <= '0;
      db_cnt    <= '0;
      db_val    <= 1'b0;
      db_prev   <= 1'b0;
      tick      <= '0;
      state     <= HALT;
      cpu_ce    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      run_q     <= {run_q[0], run};
      step_q    <= {step_q[0], step};
      div_q     <= div_sel;
      db_prev   <= db_val;
      db_cnt    <= (step_s == db_val || db_cnt == DB_CYCLES - 1) ? '0 : db_cnt + 1;
      db_val    <= (step_s != db_val && db_cnt == DB_CYCLES - 1) ? step_s : db_val;
      tick      <= (stay_run && !div_chg && tick != period - 1) ? tick + 1 : '0;
      state     <= state_n;
      cpu_ce    <= ce_n;
      cycle_cnt <= cycle_cnt + 32'(cpu_ce);
    end
  end
endmodule
